timer_counter: RTL

- Minutes:seconds countdown datapath driven by the timer control state machine's enableCounter / forward / resetTimer outputs.
- In setting mode it increments minutes and seconds on operator demand.
- In count mode it decrements once per second derived from clk, and reports expiry.
- BCD outputs feed the VGA digit renderer directly.

---
 rtl/timer_pkg.sv | 41 ++++
 rtl/tick_prescaler.sv | 30 +++
 rtl/timer_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, field limit and BCD helper for timer_counter
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUN     = 3'd2,
    ST_HOLD    = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  // Wrap limit shared by the minutes and seconds fields.
  localparam logic [5:0] MAX_VAL = 6'd59;

  // Two-digit BCD {tens,ones} for a 0..59 binary field.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a one-cycle tick every TICK_DIV running cycles
// Ports: clk; run (advance count); clear (force count to 0, wins over run);
//        tick (high in the cycle the count sits at TICK_DIV-1 while running).
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = run && (r_count == LAST);

  // Count is only frozen (not cleared) when run drops, so a partial
  // second survives a pause.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - minutes:seconds set / count-down datapath with BCD outputs
// Optional feature macro: TIMER_BEEP_EN (adds beep output).
// Ports: clk, reset (sync, active high); enable_counter, forward, reset_timer from
//        the control FSM; seg_demand / min_demand increment levels (edge-detected);
//        sec_bcd / min_bcd registered BCD time; tick, done one-cycle pulses;
//        expired level; beep (only with TIMER_BEEP_EN).
module timer_counter
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_counter,
  input  logic       forward,
  input  logic       reset_timer,
  input  logic       seg_demand,
  input  logic       min_demand,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       tick,
  output logic       done,
  output logic       expired
`ifdef TIMER_BEEP_EN
  ,
  output logic       beep
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic       r_seg_dem_q;
  logic       r_min_dem_q;
  logic       r_expired;

  logic       w_time_zero;
  logic       w_set;
  logic       w_run;
  logic       w_inc_sec;
  logic       w_inc_min;
  logic       w_pre_run;
  logic       w_pre_clear;
  logic       w_ptick;

`ifdef TIMER_BEEP_EN
  logic       r_beep;
  logic [1:0] r_beep_ticks;
  logic       w_beep_kill;
  logic       w_beep_end;
`endif

  assign w_time_zero = (r_sec == 6'd0) && (r_min == 6'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. The mode is decided from this cycle's inputs and also governs
  // this cycle's action, so the datapath reacts without a cycle of lag.
  always_comb begin
    w_state_nxt = r_state;
    if (reset_timer) begin
      w_state_nxt = ST_IDLE;
    end else if (enable_counter && forward) begin
      w_state_nxt = ST_SET;
    end else if (enable_counter) begin
      w_state_nxt = w_time_zero ? ST_EXPIRED : ST_RUN;
    end else if (!w_time_zero) begin
      w_state_nxt = ST_HOLD;
    end else if (r_state == ST_EXPIRED) begin
      w_state_nxt = ST_EXPIRED;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Per-cycle actions decoded from the chosen mode.
  always_comb begin
    w_set     = (w_state_nxt == ST_SET);
    w_run     = (w_state_nxt == ST_RUN);
    // Edge detectors update in every mode; only SET consumes the edges.
    w_inc_sec = w_set && seg_demand && !r_seg_dem_q;
    w_inc_min = w_set && min_demand && !r_min_dem_q;
    tick      = w_ptick && w_run;
    // Only a decrement from 00:01 lands on 00:00.
    done      = tick && (r_min == 6'd0) && (r_sec == 6'd1);
  end

`ifdef TIMER_BEEP_EN
  assign w_pre_run   = w_run || (r_beep && (w_state_nxt == ST_EXPIRED));
`else
  assign w_pre_run   = w_run;
`endif
  assign w_pre_clear = reset || reset_timer || w_set;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .run  (w_pre_run),
    .clear(w_pre_clear),
    .tick (w_ptick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec       <= 6'd0;
      r_min       <= 6'd0;
      r_seg_dem_q <= 1'b0;
      r_min_dem_q <= 1'b0;
      r_expired   <= 1'b0;
      sec_bcd     <= 8'h00;
      min_bcd     <= 8'h00;
    end else begin
      r_seg_dem_q <= seg_demand;
      r_min_dem_q <= min_demand;
      sec_bcd     <= bin2bcd(r_sec);
      min_bcd     <= bin2bcd(r_min);
      if (reset_timer) begin
        r_sec     <= 6'd0;
        r_min     <= 6'd0;
        r_expired <= 1'b0;
      end else if (w_set) begin
        if (w_inc_sec) begin
          r_sec <= (r_sec == MAX_VAL) ? 6'd0 : r_sec + 6'd1;
        end
        if (w_inc_min) begin
          r_min <= (r_min == MAX_VAL) ? 6'd0 : r_min + 6'd1;
        end
        if (w_inc_sec || w_inc_min) begin
          r_expired <= 1'b0;
        end
      end else if (tick) begin
        if (r_sec != 6'd0) begin
          r_sec <= r_sec - 6'd1;
        end else if (r_min != 6'd0) begin
          r_min <= r_min - 6'd1;
          r_sec <= MAX_VAL;
        end
        if (done) begin
          r_expired <= 1'b1;
        end
      end
    end
  end

  assign expired = r_expired;

`ifdef TIMER_BEEP_EN
  // Beep spans the done cycle plus the following three prescaler periods,
  // minus the final tick cycle, i.e. 3*TICK_DIV cycles in total.
  assign w_beep_kill = reset_timer || w_set;
  assign w_beep_end  = r_beep && w_ptick && (r_beep_ticks == 2'd0);
  assign beep        = !w_beep_kill && (done || (r_beep && !w_beep_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beep       <= 1'b0;
      r_beep_ticks <= 2'd0;
    end else if (w_beep_kill) begin
      r_beep       <= 1'b0;
      r_beep_ticks <= 2'd0;
    end else if (done) begin
      r_beep       <= 1'b1;
      r_beep_ticks <= 2'd2;
    end else if (r_beep && w_ptick) begin
      if (r_beep_ticks == 2'd0) begin
        r_beep <= 1'b0;
      end else begin
        r_beep_ticks <= r_beep_ticks - 2'd1;
      end
    end
  end
`endif

endmodule
